multi_band_line_error: RTL and testbench

Streaming line-follower vision block. Computes the path centroid column independently in NUM_BANDS horizontal bands of a rectangular region of interest (ROI) and reports a signed steering error per band. Sits between the camera pixel stream and the PID controller. Replaces the single-band, combinational-divide error block with a runtime channel/threshold select, valid-qualified counting and a multi-cycle sequential divider.

---
 rtl/multi_band_line_error_if.sv | 25 ++
 rtl/multi_band_line_error.sv | 204 ++++++++++++++++++++
 tb/tb_multi_band_line_error.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/multi_band_line_error_if.sv
// rtl/multi_band_line_error_if.sv - pixel stream in, per-band steering result out
interface multi_band_line_error_if #(
  parameter int COLOUR_BITS = 4
);
  logic [3*COLOUR_BITS-1:0] pixel;
  logic                     pixel_valid;
  logic                     startofpacket;
  logic [1:0]               channel_sel;
  logic [COLOUR_BITS-1:0]   threshold;
  logic signed [31:0]       error;
  logic [2:0]               band_index;
  logic                     error_valid;
  logic                     line_lost;
  logic                     frame_done;

  modport master (
    output pixel, pixel_valid, startofpacket, channel_sel, threshold,
    input  error, band_index, error_valid, line_lost, frame_done
  );

  modport slave (
    input  pixel, pixel_valid, startofpacket, channel_sel, threshold,
    output error, band_index, error_valid, line_lost, frame_done
  );
endinterface

// File: rtl/multi_band_line_error.sv
// rtl/multi_band_line_error.sv - per-band path centroid with sequential restoring divider
module multi_band_line_error #(
  parameter int IMAGE_WIDTH  = 320,
  parameter int IMAGE_HEIGHT = 240,
  parameter int COLOUR_BITS  = 4,
  parameter int NUM_BANDS    = 3,
  parameter int ROI_TOP      = 109,
  parameter int ROI_BOTTOM   = 229,
  parameter int ROI_LEFT     = 106,
  parameter int ROI_RIGHT    = 211,
  parameter int MIN_PIXELS   = 8
) (
  input logic                    clk,
  input logic                    reset,
  multi_band_line_error_if.slave bus
);
  localparam int QW     = $clog2(IMAGE_WIDTH);
  localparam int CW     = $clog2(IMAGE_WIDTH);
  localparam int RW     = $clog2(IMAGE_HEIGHT + 1);
  localparam int SW     = $clog2(IMAGE_WIDTH * IMAGE_WIDTH * IMAGE_HEIGHT + 1);
  localparam int NW     = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT + 1);
  localparam int BW     = $clog2(NUM_BANDS + 1);
  localparam int SCW    = $clog2(QW);
  localparam int BAND_H = (ROI_BOTTOM - ROI_TOP + 1) / NUM_BANDS;

  typedef enum logic [1:0] {IDLE, DIV, OUT} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      col_q, col_d;
  logic [RW-1:0]      row_q, row_d;
  logic [BW-1:0]      band_q, band_d;
  logic [SW-1:0]      x_sum_q, x_sum_d;
  logic [NW-1:0]      count_q, count_d;
  logic               start_q, start_d;
  logic               low_q, low_d;
  logic [2:0]         div_band_q, div_band_d;
  logic [SW-1:0]      rem_q, rem_d;
  logic [SW+QW-1:0]   dvs_q, dvs_d;
  logic [QW-1:0]      quot_q, quot_d;
  logic [SCW-1:0]     step_q, step_d;
  logic signed [31:0] error_q, error_d;
  logic [2:0]         band_index_q, band_index_d;
  logic               error_valid_q, error_valid_d;
  logic               line_lost_q, line_lost_d;
  logic               frame_done_q, frame_done_d;

  logic                   sop, hit, close;
  logic [CW-1:0]          cur_col;
  logic [RW-1:0]          cur_row;
  logic [COLOUR_BITS-1:0] chan;
  logic [SW-1:0]          acc_sum;
  logic [NW-1:0]          acc_cnt;
  int                     band_last;

  // Position of the pixel being presented; an SOP pixel is (0,0) whatever the counters hold.
  always_comb begin
    sop     = bus.pixel_valid & bus.startofpacket;
    cur_col = sop ? '0 : col_q;
    cur_row = sop ? '0 : row_q;
    case (bus.channel_sel)
      2'b01:   chan = bus.pixel[3*COLOUR_BITS-1:2*COLOUR_BITS];
      2'b10:   chan = bus.pixel[2*COLOUR_BITS-1:COLOUR_BITS];
      default: chan = bus.pixel[COLOUR_BITS-1:0];
    endcase
    hit = bus.pixel_valid && (bus.channel_sel != 2'b00) && (chan >= bus.threshold) &&
          (int'(cur_row) >= ROI_TOP) && (int'(cur_row) <= ROI_BOTTOM) &&
          (int'(cur_col) >= ROI_LEFT) && (int'(cur_col) <= ROI_RIGHT);
    band_last = (int'(band_q) == NUM_BANDS - 1) ? ROI_BOTTOM
                                                : ROI_TOP + (int'(band_q) + 1) * BAND_H - 1;
    close = bus.pixel_valid && !sop && (int'(band_q) < NUM_BANDS) &&
            (int'(cur_row) == band_last) && (int'(cur_col) == ROI_RIGHT);

    acc_sum = sop ? '0 : x_sum_q;
    acc_cnt = sop ? '0 : count_q;
    if (hit) begin
      acc_sum = acc_sum + SW'(cur_col);
      acc_cnt = acc_cnt + NW'(1);
    end

    col_d   = col_q;
    row_d   = row_q;
    band_d  = sop ? '0 : band_q;
    x_sum_d = acc_sum;
    count_d = acc_cnt;
    if (bus.pixel_valid) begin
      col_d = cur_col;
      row_d = cur_row;
      if (int'(cur_row) < IMAGE_HEIGHT) begin
        if (int'(cur_col) == IMAGE_WIDTH - 1) begin
          col_d = '0;
          row_d = cur_row + RW'(1);
        end else begin
          col_d = cur_col + CW'(1);
        end
      end
    end
    if (close) begin
      x_sum_d = '0;
      count_d = '0;
      band_d  = band_q + BW'(1);
    end
  end

  // Band closes never overlap a running division, so the divider registers are loaded directly.
  always_comb begin
    state_d       = state_q;
    rem_d         = rem_q;
    dvs_d         = dvs_q;
    quot_d        = quot_q;
    step_d        = step_q;
    low_d         = low_q;
    div_band_d    = div_band_q;
    start_d       = 1'b0;
    error_d       = error_q;
    band_index_d  = band_index_q;
    line_lost_d   = line_lost_q;
    error_valid_d = 1'b0;
    frame_done_d  = 1'b0;
    if (close) begin
      rem_d      = acc_sum;
      dvs_d      = (SW+QW)'(acc_cnt) << (QW - 1);
      quot_d     = '0;
      step_d     = '0;
      low_d      = acc_cnt < NW'(MIN_PIXELS);
      div_band_d = 3'(band_q);
      start_d    = 1'b1;
    end
    if (sop) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (start_q) state_d = low_q ? OUT : DIV;
        DIV: begin
          if ({{QW{1'b0}}, rem_q} >= dvs_q) begin
            rem_d  = rem_q - dvs_q[SW-1:0];
            quot_d = {quot_q[QW-2:0], 1'b1};
          end else begin
            quot_d = {quot_q[QW-2:0], 1'b0};
          end
          dvs_d  = dvs_q >> 1;
          step_d = step_q + SCW'(1);
          if (step_q == SCW'(QW - 1)) state_d = OUT;
        end
        OUT: begin
          error_valid_d = 1'b1;
          band_index_d  = div_band_q;
          frame_done_d  = (div_band_q == 3'(NUM_BANDS - 1));
          line_lost_d   = low_q;
          if (!low_q) error_d = 32'(IMAGE_WIDTH / 2) - 32'(quot_q);
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      col_q         <= '0;
      row_q         <= '0;
      band_q        <= '0;
      x_sum_q       <= '0;
      count_q       <= '0;
      start_q       <= 1'b0;
      low_q         <= 1'b0;
      div_band_q    <= '0;
      rem_q         <= '0;
      dvs_q         <= '0;
      quot_q        <= '0;
      step_q        <= '0;
      error_q       <= '0;
      band_index_q  <= '0;
      error_valid_q <= 1'b0;
      line_lost_q   <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      row_q         <= row_d;
      band_q        <= band_d;
      x_sum_q       <= x_sum_d;
      count_q       <= count_d;
      start_q       <= start_d;
      low_q         <= low_d;
      div_band_q    <= div_band_d;
      rem_q         <= rem_d;
      dvs_q         <= dvs_d;
      quot_q        <= quot_d;
      step_q        <= step_d;
      error_q       <= error_d;
      band_index_q  <= band_index_d;
      error_valid_q <= error_valid_d;
      line_lost_q   <= line_lost_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign bus.error       = error_q;
  assign bus.band_index  = band_index_q;
  assign bus.error_valid = error_valid_q;
  assign bus.line_lost   = line_lost_q;
  assign bus.frame_done  = frame_done_q;
endmodule

// File: tb/tb_multi_band_line_error.sv
// tb/tb_multi_band_line_error.sv - frame-level reference model bench on a scaled-down image
module tb_multi_band_line_error;
  localparam int W      = 32;
  localparam int H      = 24;
  localparam int CB     = 4;
  localparam int NB     = 3;
  localparam int TOP    = 4;
  localparam int BOT    = 20;
  localparam int LEFT   = 8;
  localparam int RIGHT  = 23;
  localparam int MINP   = 8;
  localparam int QW     = $clog2(W);
  localparam int BAND_H = (BOT - TOP + 1) / NB;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multi_band_line_error_if #(.COLOUR_BITS(CB)) bus ();

  multi_band_line_error #(
    .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .COLOUR_BITS(CB), .NUM_BANDS(NB),
    .ROI_TOP(TOP), .ROI_BOTTOM(BOT), .ROI_LEFT(LEFT), .ROI_RIGHT(RIGHT),
    .MIN_PIXELS(MINP)
  ) u_dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    int     band;
    longint sum;
    int     cnt;
    int     due;
  } exp_t;

  exp_t            pend[$];
  longint          held = 0;
  logic [3*CB-1:0] fr [H][W];
  longint          bsum [NB];
  int              bcnt [NB];
  int              blast [NB];
  logic [1:0]      csel;
  logic [CB-1:0]   thr;

  task automatic chk(string tag, logic signed [63:0] obs, logic signed [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int chanval(logic [3*CB-1:0] p, logic [1:0] s);
    case (s)
      2'd1:    return int'(p[3*CB-1:2*CB]);
      2'd2:    return int'(p[2*CB-1:CB]);
      2'd3:    return int'(p[CB-1:0]);
      default: return -1;
    endcase
  endfunction

  // Selected channel is pushed at/above threshold inside the stripe and below it elsewhere.
  task automatic gen_frame(int clo, int chi, int rlo, int rhi, bit white);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        logic [3*CB-1:0] p;
        int v;
        int sh;
        p = (3*CB)'($urandom);
        if (white) begin
          p = '1;
        end else if (csel != 2'd0) begin
          if (r >= rlo && r <= rhi && c >= clo && c <= chi) v = int'($urandom_range(15, int'(thr)));
          else v = int'($urandom_range(int'(thr) - 1, 0));
          sh = (3 - int'(csel)) * CB;
          p[sh +: CB] = CB'(v);
        end
        fr[r][c] = p;
      end
    end
  endtask

  task automatic model_bands();
    for (int b = 0; b < NB; b++) begin
      int rs;
      int re;
      rs = TOP + b * BAND_H;
      re = (b == NB - 1) ? BOT : rs + BAND_H - 1;
      bsum[b]  = 0;
      bcnt[b]  = 0;
      blast[b] = re;
      for (int r = rs; r <= re; r++)
        for (int c = LEFT; c <= RIGHT; c++)
          if (chanval(fr[r][c], csel) >= int'(thr)) begin
            bsum[b] += c;
            bcnt[b]++;
          end
    end
  endtask

  task automatic watch();
    exp_t   e;
    longint eerr;
    bit     ell;
    if (bus.error_valid === 1'b1) begin
      if (pend.size() == 0) begin
        chk("unexpected_valid", bus.error_valid, 0);
      end else begin
        e = pend.pop_front();
        if (e.cnt < MINP) begin
          ell  = 1'b1;
          eerr = held;
        end else begin
          ell  = 1'b0;
          eerr = W / 2 - e.sum / e.cnt;
          held = eerr;
        end
        chk("band_index", bus.band_index, e.band);
        chk("error", bus.error, eerr);
        chk("line_lost", bus.line_lost, ell);
        chk("frame_done", bus.frame_done, e.band == NB - 1);
        chk("latency", cyc, e.due);
      end
    end else begin
      chk("frame_done_idle", bus.frame_done, 0);
      if (pend.size() > 0 && cyc > pend[0].due) begin
        chk("missing_valid", bus.error_valid, 1);
        void'(pend.pop_front());
      end
    end
  endtask

  task automatic step(logic v, logic s, logic [3*CB-1:0] p);
    bus.pixel_valid   = v;
    bus.startofpacket = s;
    bus.pixel         = p;
    bus.channel_sel   = csel;
    bus.threshold     = thr;
    @(posedge clk);
    #1;
    if (reset) begin
      pend.delete();
      held = 0;
    end else if (v && s) begin
      while (pend.size() > 0 && pend[$].due >= cyc) void'(pend.pop_back());
    end
    watch();
  endtask

  task automatic send_frame(int pct, int stop_r, int stop_c);
    model_bands();
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        while (int'($urandom_range(99, 0)) >= pct) step(1'b0, 1'($urandom), (3*CB)'($urandom));
        step(1'b1, (r == 0 && c == 0), fr[r][c]);
        for (int b = 0; b < NB; b++)
          if (r == blast[b] && c == RIGHT)
            pend.push_back('{b, bsum[b], bcnt[b], cyc + ((bcnt[b] < MINP) ? 2 : QW + 2)});
        if (r == stop_r && c == stop_c) return;
      end
    end
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_error"}, bus.error, 0);
    chk({tag, "_band_index"}, bus.band_index, 0);
    chk({tag, "_error_valid"}, bus.error_valid, 0);
    chk({tag, "_line_lost"}, bus.line_lost, 0);
    chk({tag, "_frame_done"}, bus.frame_done, 0);
  endtask

  initial begin
    int lo;
    csel  = 2'd2;
    thr   = CB'(15);
    reset = 1'b1;
    repeat (3) step(1'b0, 1'b0, '0);
    check_zero("reset");
    reset = 1'b0;

    csel = 2'd0;
    gen_frame(0, 0, 0, 0, 1'b1);
    send_frame(100, -1, -1);

    csel = 2'd2;
    thr  = CB'(15);
    gen_frame(14, 17, 0, H - 1, 1'b0);
    send_frame(100, -1, -1);

    gen_frame(LEFT, LEFT + 9, TOP, TOP + BAND_H - 1, 1'b0);
    send_frame(100, -1, -1);

    gen_frame(14, 17, 0, H - 1, 1'b0);
    send_frame(50, -1, -1);

    for (int k = 0; k < 4; k++) begin
      csel = 2'($urandom_range(3, 1));
      thr  = CB'($urandom_range(15, 1));
      lo   = int'($urandom_range(RIGHT, LEFT - 3));
      gen_frame(lo, lo + int'($urandom_range(7, 0)), int'($urandom_range(10, 0)),
                int'($urandom_range(H - 1, 8)), 1'b0);
      send_frame(int'($urandom_range(100, 40)), -1, -1);
    end

    csel = 2'd2;
    thr  = CB'(15);
    gen_frame(14, 17, 0, H - 1, 1'b0);
    send_frame(100, TOP + BAND_H + 2, 5);
    gen_frame(20, 22, 0, H - 1, 1'b0);
    send_frame(100, -1, -1);

    gen_frame(14, 17, 0, H - 1, 1'b0);
    send_frame(100, TOP + BAND_H - 1, RIGHT + 1);
    gen_frame(9, 12, 0, H - 1, 1'b0);
    send_frame(100, -1, -1);

    gen_frame(14, 17, 0, H - 1, 1'b0);
    send_frame(100, TOP + BAND_H - 1, RIGHT + 3);
    reset = 1'b1;
    step(1'b0, 1'b0, '0);
    check_zero("reset_in_div");
    reset = 1'b0;
    gen_frame(10, 13, 0, H - 1, 1'b0);
    send_frame(100, -1, -1);

    repeat (40) step(1'b0, 1'b0, '0);
    chk("pending_results", pend.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
